// File: rtl/csr_pkg.sv
// csr_pkg: privilege/operation types and the counter/timer CSR address map
package csr_pkg;
  typedef enum logic [1:0] {PRIV_U = 2'b00, PRIV_S = 2'b01, PRIV_M = 2'b11} priv_mode_t;
  typedef enum logic [1:0] {CSR_RW = 2'b01, CSR_RS = 2'b10, CSR_RC = 2'b11} csr_op_t;
  localparam logic [11:0] CSR_MCYCLE = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHPM_BASE = 12'hB03;
  localparam logic [11:0] CSR_CYCLE = 12'hC00;
  localparam logic [11:0] CSR_TIME = 12'hC01;
  localparam logic [11:0] CSR_HIGH_OFFSET = 12'h080;
  localparam logic [11:0] CSR_MCOUNTEREN = 12'h306;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
endpackage

// File: rtl/csr_counter.sv
// csr_counter: one counter with half-word writes that take priority over the increment
module csr_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             inhibit,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  output logic [WIDTH-1:0] value
);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) value <= '0;
    else if (wr_lo) value <= {value[WIDTH-1:32], wdata};
    else if (wr_hi) value <= {wdata[WIDTH-33:0], value[31:0]};
    else if (inc && !inhibit) value <= value + WIDTH'(1);
endmodule

// File: rtl/csr_counter_bank.sv
// csr_counter_bank: mcycle/time/minstret/mhpmcounter CSRs with Zicsr RW/RS/RC access and privilege checks
module csr_counter_bank
  import csr_pkg::*;
#(
  parameter int NUM_HPM = 4,
  parameter int COUNTER_WIDTH = 64,
  parameter int TIME_DIV = 1
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  priv_mode_t                          priv_mode,
  input  logic                                instr_retired,
  input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_event,
  input  logic                                req_valid,
  input  logic [11:0]                         req_addr,
  input  csr_op_t                             req_op,
  input  logic [31:0]                         req_wdata,
  input  logic                                req_write,
  output logic                                resp_valid,
  output logic [31:0]                         resp_rdata,
  output logic                                resp_illegal
);
  localparam int DW = TIME_DIV > 1 ? $clog2(TIME_DIV) : 1;
  // Slot n of the bank is CSR 0xB00+n / 0xC00+n; slot 1 is time, visible only through 0xC01/0xC81
  localparam logic [31:0] CTR_MASK = 32'((33'(1) << (3 + NUM_HPM)) - 33'(1)) & ~32'h2;
  localparam logic [31:0] RD_MASK = CTR_MASK | 32'h2;
  localparam logic [11:0] HI_M = CSR_MCYCLE | CSR_HIGH_OFFSET;
  localparam logic [11:0] HI_U = CSR_CYCLE | CSR_HIGH_OFFSET;
  logic [COUNTER_WIDTH-1:0] ctr [32];
  logic [31:0] inhibit, counteren, inc, wr_lo, wr_hi, old, nxt;
  logic [63:0] sel;
  logic [DW-1:0] div;
  logic [4:0] idx;
  logic tick, lo_m, hi_m, lo_u, hi_u, is_en, is_inh, m_ok, u_ok, illegal, wr;
  assign tick = div == DW'(TIME_DIV - 1);
  assign inc = 32'({hpm_event, instr_retired, tick, 1'b1});
  always_comb begin
    idx = req_addr[4:0];
    lo_m = req_addr[11:5] == CSR_MCYCLE[11:5];
    hi_m = req_addr[11:5] == HI_M[11:5];
    lo_u = req_addr[11:5] == CSR_CYCLE[11:5];
    hi_u = req_addr[11:5] == HI_U[11:5];
    is_en = req_addr == CSR_MCOUNTEREN;
    is_inh = req_addr == CSR_MCOUNTINHIBIT;
    m_ok = (lo_m || hi_m) && CTR_MASK[idx];
    u_ok = (lo_u || hi_u) && RD_MASK[idx];
    illegal = !(m_ok || u_ok || is_en || is_inh)
      || (priv_mode != PRIV_M && !(u_ok && counteren[idx]))
      || (u_ok && req_write);
    sel = 64'(ctr[idx]);
    old = is_en ? counteren : is_inh ? inhibit : (hi_m || hi_u) ? sel[63:32] : sel[31:0];
    nxt = req_op == CSR_RW ? req_wdata : req_op == CSR_RS ? (old | req_wdata) : (old & ~req_wdata);
    wr = req_valid && !illegal && req_write;
    wr_lo = (wr && lo_m) ? 32'(1) << idx : '0;
    wr_hi = (wr && hi_m) ? 32'(1) << idx : '0;
  end
  for (genvar i = 0; i < 32; i++) begin : g_ctr
    if (RD_MASK[i]) begin : g_on
      csr_counter #(.WIDTH(COUNTER_WIDTH)) u_ctr (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (inc[i]),
        .inhibit (inhibit[i]),
        .wr_lo   (wr_lo[i]),
        .wr_hi   (wr_hi[i]),
        .wdata   (nxt),
        .value   (ctr[i])
      );
    end else begin : g_off
      assign ctr[i] = '0;
    end
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      div <= '0;
      inhibit <= '0;
      counteren <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_illegal <= 1'b0;
    end else begin
      div <= tick ? '0 : div + DW'(1);
      if (wr && is_inh) inhibit <= nxt & CTR_MASK;
      if (wr && is_en) counteren <= nxt & CTR_MASK;
      resp_valid <= req_valid;
      resp_illegal <= req_valid && illegal;
      resp_rdata <= (req_valid && !illegal) ? old : '0;
    end
endmodule

// File: doc/csr_counter_bank.md
# csr_counter_bank

Parametrised RISC-V counter/timer CSR bank: mcycle, minstret, time and NUM_HPM hardware performance counters, with mcountinhibit and mcounteren. It executes Zicsr read-modify-write operations (RW/RS/RC) through a valid/response handshake with a one-cycle registered response. It sits beside the CSR file in the execute stage. Decode supplies the operation; illegal accesses are reported back to the trap logic.

## Interface
Parameters:
- NUM_HPM, default 4: number of mhpmcounter3..(3+NUM_HPM-1); legal range 0–29.
- COUNTER_WIDTH, default 64: implemented counter width; legal range 33–64. Bits above it read 0 and ignore writes.
- TIME_DIV, default 1: clock cycles per time tick; must be ≥1.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- priv_mode  in  priv_mode_t  current privilege level (U/S/M).
- instr_retired  in  1  one instruction retired this cycle.
- hpm_event  in  NUM_HPM  per-counter event pulse; bit i drives mhpmcounter(3+i).
- req_valid  in  1  CSR access request this cycle.
- req_addr  in  12  CSR address.
- req_op  in  csr_op_t  CSR_RW / CSR_RS / CSR_RC.
- req_wdata  in  32  rs1 value or zero-extended uimm.
- req_write  in  1  0 when RS/RC has rs1=x0/uimm=0, i.e. read only.
- resp_valid  out  1  response for the previous cycle's request.
- resp_rdata  out  32  old CSR value.
- resp_illegal  out  1  access illegal; no state changed.

## Operation
- Address map:
  - Machine counters: mcycle 0xB00/0xB80, minstret 0xB02/0xB82, mhpmcounterN 0xB00+N / 0xB80+N.
  - User shadows (read-only): cycle 0xC00/0xC80, time 0xC01/0xC81, instret 0xC02/0xC82, hpmcounterN 0xC00+N / 0xC80+N.
  - Control: mcounteren 0x306, mcountinhibit 0x320.
- The 0xB8x, 0xC8x and 0xC81 high halves hold bits [COUNTER_WIDTH-1:32].
- Increment rules:
  - mcycle increments every cycle unless inhibit bit 0 is set.
  - minstret increments on instr_retired unless inhibit bit 2 is set.
  - mhpmcounterN increments on hpm_event[N-3] unless inhibit bit N is set.
  - time increments once every TIME_DIV cycles, is never inhibited, and is not writable.
- Counters wrap from 2^COUNTER_WIDTH−1 to 0 silently.
- mcountinhibit and mcounteren: bits 0, 2 and 3..(2+NUM_HPM) are writable; all others read 0. mcountinhibit bit 1 is hardwired 0.
- New-value computation: RW gives wdata; RS gives old|wdata; RC gives old&~wdata.
  - A write to a low half replaces bits [31:0] and keeps the upper bits.
  - A write to a high half replaces the upper bits and keeps the low bits.
- Illegal access (resp_illegal=1, resp_rdata=0, no update):
  - the address is not in the map, including unimplemented HPM indices;
  - a 0xBxx or 0x3xx address is accessed below M-mode;
  - a 0xCxx address is accessed below M-mode while the matching mcounteren bit is 0;
  - req_write=1 to any 0xCxx address.
- A write updates the counter's current value. The increment of that counter in the same cycle is dropped: the write wins.
- A read returns the value before this cycle's increment.

## Timing
- Request sampled at posedge when req_valid=1. resp_valid, resp_rdata and resp_illegal are registered and appear next cycle.
- Back-to-back requests are accepted every cycle; there is no stall.
- A read immediately after a write to the same CSR returns the written value, plus any increment in the intervening cycle.
- Reset (async assert, sync deassert by the environment) clears:
  - all counters, time, the TIME_DIV prescaler, mcountinhibit and mcounteren;
  - resp_valid, resp_rdata and resp_illegal.
- A request in flight during reset is dropped: no response is produced.

## Structure
- csr_pkg gains:
  - csr_op_t;
  - the address constants CSR_MCYCLE, CSR_MINSTRET, CSR_MHPM_BASE, CSR_CYCLE, CSR_TIME, CSR_HIGH_OFFSET, CSR_MCOUNTEREN, CSR_MCOUNTINHIBIT.
- Sub-module csr_counter (parameter WIDTH) handles one counter. Its inputs are inc, inhibit, wr_lo, wr_hi and wdata; it outputs value. The bank instantiates it for mcycle, minstret and each HPM counter.
- Decode/privilege checks and the RW/RS/RC datapath stay in csr_counter_bank.

## Test plan
- Reset release, 10 cycles idle, then read 0xC00 in M-mode -> resp_rdata=10 next cycle, resp_illegal=0.
- RW 0xB00 with 0xFFFFFFFF, then RW 0xB80 with 0xFFFFFFFF (COUNTER_WIDTH=64), then idle -> mcycle wraps to 0. A read of 0xB80 two cycles later returns 0.
- Set mcountinhibit=0x4, pulse instr_retired 5 times, clear mcountinhibit, pulse 3 times -> minstret=3.
- U-mode read 0xC02 with mcounteren=0 -> resp_illegal=1. Set mcounteren=0x4, repeat -> legal read. U-mode access to 0xB02 -> illegal.
- RS 0xB03 with 0x0F while hpm_event[0]=1 in the same cycle -> counter = old|0x0F with no increment. RC with 0x03 -> bits 1:0 cleared. Access to 0xB03+NUM_HPM -> illegal.
- Assert reset_n=0 mid-request -> no resp_valid. All counters read 0 after release.
